board_status_ctrl: RTL and testbench

//  Board housekeeping for the FPGA top level, sitting between the board pins and the SvarogSoC instance.

---
 rtl/board_pkg.sv | 29 ++
 rtl/reset_sync_stretch.sv | 50 +++++
 rtl/board_status_ctrl.sv | 150 +++++++++++++++
 tb/tb_board_status_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// ----------------------------------------------------------------
// board_pkg: LED mode encoding and heartbeat timing constants
// Rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package board_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_HB    = 2'b11
  } led_mode_e;

  localparam int HB_PERIOD_MS = 1000;
  localparam int HB_ON_MS     = 100;
  localparam int HB_GAP_MS    = 200;

  // Double pulse: lit for [0,ON) and [GAP,GAP+ON) of each frame.
  function automatic logic hb_level(input logic [9:0] count);
    return (count < 10'(HB_ON_MS)) ||
           ((count >= 10'(HB_GAP_MS)) && (count < 10'(HB_GAP_MS + HB_ON_MS)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sync_stretch.sv
// ----------------------------------------------------------------
// reset_sync_stretch: rst_n synchroniser plus hold counter -> soc_rst
// Rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module reset_sync_stretch #(
  parameter int RST_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic soc_rst,
  output logic rst_done
);

  localparam int c_hold_w = $clog2(RST_HOLD + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_HOLD - 1);

  logic [1:0]          r_sync;
  logic [c_hold_w-1:0] r_hold;
  logic                r_soc_rst;
  logic                r_rst_done;

  // Assertion is asynchronous; release waits for the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b00;
      r_hold     <= '0;
      r_soc_rst  <= 1'b1;
      r_rst_done <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
      if (r_soc_rst && r_sync[1]) begin
        if (r_hold == c_hold_last) begin
          r_soc_rst  <= 1'b0;
          r_rst_done <= 1'b1;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end
    end
  end

  assign soc_rst  = r_soc_rst;
  assign rst_done = r_rst_done;

endmodule

`default_nettype wire

// File: rtl/board_status_ctrl.sv
// ----------------------------------------------------------------
// board_status_ctrl: SoC reset sequencing, ms timebase, status LEDs
// Rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module board_status_ctrl
  import board_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int N_LED    = 4,
  parameter int RST_HOLD = 16,
  parameter int BLINK_MS = 500,
  parameter int ACT_MS   = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               soc_rst,
  output logic               rst_done,
  input  logic [2*N_LED-1:0] mode,
  input  logic [N_LED-1:0]   act,
  output logic               tick_ms,
  output logic [N_LED-1:0]   led
);

  if (((CLK_HZ % 1000) != 0) || (CLK_HZ < 2000)) begin : g_bad_clk
    $error("board_status_ctrl: CLK_HZ must be a multiple of 1000 and >= 2000");
  end
  if ((N_LED < 1) || (N_LED > 16)) begin : g_bad_nled
    $error("board_status_ctrl: N_LED must be in 1..16");
  end

  localparam int c_div     = CLK_HZ / 1000;
  localparam int c_presc_w = $clog2(c_div);
  localparam int c_blink_w = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int c_act_w   = $clog2(ACT_MS + 1);

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_div - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_MS - 1);
  localparam logic [9:0]           c_hb_last    = 10'(HB_PERIOD_MS - 1);
  localparam logic [c_act_w-1:0]   c_act_load   = c_act_w'(ACT_MS);

  logic                 w_soc_rst;
  logic [c_presc_w-1:0] r_presc;
  logic                 r_tick;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink;
  logic [9:0]           r_hb_cnt;
  logic                 w_hb;
  logic [N_LED-1:0]     w_led_next;
  logic [N_LED-1:0]     r_led;

  reset_sync_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_reset_sync_stretch (
    .clk      (clk),
    .rst_n    (rst_n),
    .soc_rst  (w_soc_rst),
    .rst_done (rst_done)
  );

  // tick_ms lags the terminal count by one cycle so it comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (w_soc_rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
      r_tick  <= (r_presc == c_presc_last);
    end
  end

  // Shared blink and heartbeat phase so same-mode LEDs stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_hb_cnt    <= '0;
    end else if (w_soc_rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_hb_cnt    <= '0;
    end else if (r_tick) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      r_hb_cnt <= (r_hb_cnt == c_hb_last) ? '0 : r_hb_cnt + 1'b1;
    end
  end

  assign w_hb = hb_level(r_hb_cnt);

  for (genvar i = 0; i < N_LED; i++) begin : g_led
    led_mode_e          w_mode;
    logic               w_base;
    logic [c_act_w-1:0] r_stretch;

    assign w_mode = led_mode_e'(mode[2*i +: 2]);

    always_comb begin
      w_base = 1'b0;
      case (w_mode)
        LED_OFF:   w_base = 1'b0;
        LED_ON:    w_base = 1'b1;
        LED_BLINK: w_base = r_blink;
        LED_HB:    w_base = w_hb;
        default:   w_base = 1'b0;
      endcase
    end

    // A strobe reloads the full length; a coincident tick is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stretch <= '0;
      end else if (w_soc_rst) begin
        r_stretch <= '0;
      end else if (act[i]) begin
        r_stretch <= c_act_load;
      end else if (r_tick && (r_stretch != '0)) begin
        r_stretch <= r_stretch - 1'b1;
      end
    end

    assign w_led_next[i] = w_base ^ (r_stretch != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '1;
    end else if (w_soc_rst) begin
      r_led <= '1;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign soc_rst = w_soc_rst;
  assign tick_ms = r_tick;
  assign led     = r_led;

endmodule

`default_nettype wire

// File: tb/tb_board_status_ctrl.sv
// ----------------------------------------------------------------
// tb_board_status_ctrl: directed checks of reset, timebase and LED modes
// Rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_board_status_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soc_rst;
  logic       rst_done;
  logic [3:0] mode;
  logic [1:0] act;
  logic       tick_ms;
  logic [1:0] led;

  int n_cmp = 0;
  int n_err = 0;

  board_status_ctrl #(
    .CLK_HZ   (10_000),
    .N_LED    (2),
    .RST_HOLD (4),
    .BLINK_MS (3),
    .ACT_MS   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soc_rst  (soc_rst),
    .rst_done (rst_done),
    .mode     (mode),
    .act      (act),
    .tick_ms  (tick_ms),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each step lands on a falling edge, i.e. n rising edges later.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick_ms !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_tick", {31'd0, tick_ms}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises;
    int highs;
    logic prev;

    rst_n = 1'b0;
    mode  = 4'b11_10;
    act   = 2'b00;
    step(3);
    check("rst_soc_rst",  {31'd0, soc_rst},  32'd1);
    check("rst_done",     {31'd0, rst_done}, 32'd0);
    check("rst_tick",     {31'd0, tick_ms},  32'd0);
    check("rst_led",      {30'd0, led},      32'h3);

    // Release: soc_rst falls 6 edges after rst_n rises.
    rst_n = 1'b1;
    step(5);
    check("rel5_soc_rst", {31'd0, soc_rst},  32'd1);
    check("rel5_led",     {30'd0, led},      32'h3);
    step(1);
    check("rel6_soc_rst", {31'd0, soc_rst},  32'd0);
    check("rel6_done",    {31'd0, rst_done}, 32'd1);
    check("rel6_led",     {30'd0, led},      32'h3);
    step(1);
    check("e1_led",       {30'd0, led},      32'h2);
    step(8);
    check("e9_tick",      {31'd0, tick_ms},  32'd0);
    step(1);
    check("e10_tick",     {31'd0, tick_ms},  32'd1);
    step(1);
    check("e11_tick",     {31'd0, tick_ms},  32'd0);
    step(20);
    check("blink_e31",    {31'd0, led[0]},   32'd0);
    step(1);
    check("blink_e32",    {31'd0, led[0]},   32'd1);
    step(29);
    check("blink_e61",    {31'd0, led[0]},   32'd1);
    step(1);
    check("blink_e62",    {31'd0, led[0]},   32'd0);

    // Heartbeat edges at 100, 200 and 300 ms.
    step(939);
    check("hb_e1001",     {31'd0, led[1]},   32'd1);
    step(1);
    check("hb_e1002",     {31'd0, led[1]},   32'd0);
    step(999);
    check("hb_e2001",     {31'd0, led[1]},   32'd0);
    step(1);
    check("hb_e2002",     {31'd0, led[1]},   32'd1);
    step(1000);
    check("hb_e3002",     {31'd0, led[1]},   32'd0);

    rises = 0;
    highs = 0;
    prev  = led[1];
    for (int i = 0; i < 10_000; i++) begin
      step(1);
      if (led[1] && !prev) rises++;
      if (led[1]) highs++;
      prev = led[1];
    end
    check("hb_pulses",    rises, 32'd2);
    check("hb_lit_cyc",   highs, 32'd2000);

    // Activity strobe coincident with a tick: load wins.
    mode = 4'b01_01;
    step(1);
    wait_tick();
    act = 2'b10;
    step(1);
    check("act_latency",  {31'd0, led[1]},   32'd1);
    act = 2'b00;
    step(1);
    check("act_p1",       {31'd0, led[1]},   32'd0);
    step(19);
    check("act_p20",      {31'd0, led[1]},   32'd0);
    step(1);
    check("act_p21",      {31'd0, led[1]},   32'd1);

    mode = 4'b01_00;
    #1;
    check("mode_hold",    {31'd0, led[0]},   32'd1);
    step(1);
    check("mode_next",    {31'd0, led[0]},   32'd0);

    // Retrigger one tick in: reload, not accumulate.
    wait_tick();
    act = 2'b10;
    step(1);
    act = 2'b00;
    wait_tick();
    act = 2'b10;
    step(1);
    act = 2'b00;
    step(20);
    check("retrig_p30",   {31'd0, led[1]},   32'd0);
    step(1);
    check("retrig_p31",   {31'd0, led[1]},   32'd1);

    // Asynchronous reset in the middle of a flash.
    wait_tick();
    act = 2'b10;
    step(1);
    act = 2'b00;
    step(3);
    check("flash_dark",   {31'd0, led[1]},   32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led",    {30'd0, led},      32'h3);
    check("async_soc",    {31'd0, soc_rst},  32'd1);
    check("async_done",   {31'd0, rst_done}, 32'd0);
    check("async_tick",   {31'd0, tick_ms},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    check("rel2_5_soc",   {31'd0, soc_rst},  32'd1);
    step(1);
    check("rel2_6_done",  {31'd0, rst_done}, 32'd1);
    step(1);
    check("rel2_e1_led",  {30'd0, led},      32'h2);
    step(8);
    check("rel2_e9_tick", {31'd0, tick_ms},  32'd0);
    step(1);
    check("rel2_e10_tick",{31'd0, tick_ms},  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
